// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Function : Arbitrates fetch and load/store requesters onto a byte-wide bus,
//            serialising 1/2/4-byte accesses and assembling reads little-endian.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int IF_BYTES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_addr,
  output logic        mem_wr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [2:0] IF_N     = 3'(IF_BYTES);

  logic [1:0]  state_q,    state_d;
  logic        owner_q,    owner_d;    // 1 = load/store owns the transaction
  logic [31:0] base_q,     base_d;
  logic [2:0]  nbytes_q,   nbytes_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [2:0]  cnt_q,      cnt_d;      // bytes captured (read) or written
  logic        pend_q,     pend_d;     // byte cnt_q was presented last cycle with rdy_in=1
  logic [31:0] buf_q,      buf_d;
  logic [31:0] if_data_q,  if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [31:0] merged;
  logic [2:0]  next_idx;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    nbytes_d   = nbytes_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_addr   = 32'd0;
    mem_dout   = 8'd0;
    mem_wr     = 1'b0;
    if_done    = 1'b0;
    ls_done    = 1'b0;

    merged = buf_q;
    merged[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
    next_idx = cnt_q + {2'b00, pend_q};

    case (state_q)
      ST_IDLE: begin
        if (rdy_in) begin
          cnt_d  = 3'd0;
          pend_d = 1'b0;
          buf_d  = 32'd0;
          if (ls_req) begin
            owner_d  = 1'b1;
            base_d   = ls_addr;
            wdata_d  = ls_wdata;
            nbytes_d = (ls_size == 2'b00) ? 3'd1 : (ls_size == 2'b01) ? 3'd2 : 3'd4;
            state_d  = ls_we ? ST_WRITE : ST_READ;
          end else if (if_req && !if_flush) begin
            owner_d  = 1'b0;
            base_d   = if_addr;
            nbytes_d = IF_N;
            state_d  = ST_READ;
          end
        end
      end

      ST_READ: begin
        // A paused cycle loses the in-flight byte; it is re-presented on resume.
        if (!rdy_in) begin
          pend_d = 1'b0;
        end else if (!owner_q && if_flush) begin
          state_d = ST_IDLE;
        end else if (pend_q && (cnt_q + 3'd1 == nbytes_q)) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            ls_done    = 1'b1;
            ls_rdata_d = merged;
          end else begin
            if_done    = 1'b1;
            if_data_d  = merged;
          end
        end else begin
          if (pend_q) begin
            buf_d = merged;
            cnt_d = cnt_q + 3'd1;
          end
          mem_addr = base_q + {29'd0, next_idx};
          pend_d   = 1'b1;
        end
      end

      ST_WRITE: begin
        if (rdy_in) begin
          if (cnt_q == nbytes_q) begin
            ls_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            mem_addr = base_q + {29'd0, cnt_q};
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = 1'b1;
            cnt_d    = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Completed data is visible in the done cycle and held afterwards.
    if_data  = if_data_d;
    ls_rdata = ls_rdata_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      base_q     <= 32'd0;
      nbytes_q   <= 3'd0;
      wdata_q    <= 32'd0;
      cnt_q      <= 3'd0;
      pend_q     <= 1'b0;
      buf_q      <= 32'd0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      base_q     <= base_d;
      nbytes_q   <= nbytes_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Function : Self-checking bench for mem_ctrl with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, if_req, if_flush, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic [7:0]  mem_din;
  logic        if_done, ls_done, mem_wr;
  logic [31:0] if_data, ls_rdata, mem_addr;
  logic [7:0]  mem_dout;

  typedef struct packed { logic is_ls; logic [31:0] data; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;

  exp_t       sb[$];
  wr_t        wr_log[$];
  logic [7:0] ram [0:4095];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  mem_ctrl #(.IF_BYTES(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_addr(mem_addr), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read RAM: data for an address appears the cycle after it.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_addr[11:0]];
    if (mem_wr) wr_log.push_back('{mem_addr, mem_dout});
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_flush = 1'b0; ls_req = 1'b0;
    ls_we = 1'b0; if_addr = '0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    repeat (2) tick();
    #1;
    total_cnt++;
    if ({if_done, ls_done, mem_wr, mem_addr, mem_dout, if_data, ls_rdata} !== '0)
      $display("FAIL reset_outputs got addr=%h wr=%b dout=%h ifd=%h lsd=%h expected all 0",
               mem_addr, mem_wr, mem_dout, if_data, ls_rdata);
    else pass_cnt++;
    rst_in = 1'b0;
  endtask

  task automatic test_fetch();
    int   done_cyc;
    bit   wr_seen;
    exp_t e;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    sb.push_back('{1'b0, 32'h00000513});
    tick(); if_req = 1'b1; if_addr = 32'h100; #1;
    done_cyc = -1; wr_seen = 1'b0;
    for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
      tick(); #1;
      if (mem_wr) wr_seen = 1'b1;
      if (c <= 4) begin
        total_cnt++;
        if (mem_addr !== 32'(32'h100 + c - 1))
          $display("FAIL fetch_addr cycle %0d got %h expected %h", c, mem_addr, 32'(32'h100 + c - 1));
        else pass_cnt++;
      end
      if (if_done) begin
        done_cyc = c; e = sb.pop_front(); if_req = 1'b0;
        total_cnt++;
        if (if_data !== e.data || e.is_ls) $display("FAIL fetch_data got %h expected %h", if_data, e.data);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_cyc != 5) $display("FAIL fetch_latency got %0d expected 5", done_cyc); else pass_cnt++;
    total_cnt++;
    if (wr_seen) $display("FAIL fetch_no_write got mem_wr=1 expected 0"); else pass_cnt++;
  endtask

  task automatic test_store_arb();
    int   ls_cyc, if_cyc, fstart, wbase;
    exp_t e;
    wbase = wr_log.size();
    sb.push_back('{1'b1, 32'h0});
    sb.push_back('{1'b0, 32'h00000513});
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_wdata = 32'h41;
    if_req = 1'b1; if_addr = 32'h100; #1;
    ls_cyc = -1; if_cyc = -1; fstart = -1;
    for (int c = 1; c <= 15 && if_cyc < 0; c++) begin
      tick(); #1;
      if (c == 1) begin
        total_cnt++;
        if ({mem_wr, mem_addr, mem_dout} !== {1'b1, 32'h30000, 8'h41})
          $display("FAIL store_beat got wr=%b addr=%h dout=%h expected 1 00030000 41", mem_wr, mem_addr, mem_dout);
        else pass_cnt++;
      end
      if (fstart < 0 && mem_addr == 32'h100) fstart = c;
      if (ls_done) begin
        ls_cyc = c; e = sb.pop_front(); ls_req = 1'b0; ls_we = 1'b0;
        total_cnt++;
        if (!e.is_ls) $display("FAIL arb_order got ls_done expected if_done first"); else pass_cnt++;
      end
      if (if_done) begin
        if_cyc = c; e = sb.pop_front(); if_req = 1'b0;
        total_cnt++;
        if (if_data !== e.data || e.is_ls) $display("FAIL arb_fetch_data got %h expected %h", if_data, e.data);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (ls_cyc != 2 || fstart != 4 || if_cyc != 8)
      $display("FAIL arb_timing got ls=%0d fstart=%0d if=%0d expected 2 4 8", ls_cyc, fstart, if_cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() - wbase != 1) $display("FAIL store_beats got %0d expected 1", wr_log.size() - wbase);
    else pass_cnt++;
  endtask

  task automatic test_load();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    int          lats  [2];
    int          done_cyc;
    exp_t        e;
    addrs = '{32'h1FF, 32'h200}; sizes = '{2'b01, 2'b11}; lats = '{3, 5};
    ram[12'h1FF] = 8'h34; ram[12'h200] = 8'h12; ram[12'h201] = 8'h56;
    ram[12'h202] = 8'h78; ram[12'h203] = 8'h9A;
    sb.push_back('{1'b1, 32'h00001234});
    sb.push_back('{1'b1, 32'h9A785612});
    for (int j = 0; j < 2; j++) begin
      tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = addrs[j]; ls_size = sizes[j]; #1;
      done_cyc = -1;
      for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
        tick(); #1;
        if (ls_done) begin
          done_cyc = c; e = sb.pop_front(); ls_req = 1'b0;
          total_cnt++;
          if (ls_rdata !== e.data) $display("FAIL load_data[%0d] got %h expected %h", j, ls_rdata, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (done_cyc != lats[j]) $display("FAIL load_latency[%0d] got %0d expected %0d", j, done_cyc, lats[j]);
      else pass_cnt++;
      tick(); #1;
      total_cnt++;
      if (ls_rdata !== e.data) $display("FAIL load_hold[%0d] got %h expected %h", j, ls_rdata, e.data);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_pause();
    int   done_cyc, wbase;
    bit   wr_in_pause;
    wr_t  exp_beats [4];
    exp_beats = '{'{32'h400, 8'hEF}, '{32'h401, 8'hBE}, '{32'h402, 8'hAD}, '{32'h403, 8'hDE}};
    wbase = wr_log.size();
    sb.push_back('{1'b1, 32'h0});
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h400; ls_size = 2'b10; ls_wdata = 32'hDEADBEEF; #1;
    done_cyc = -1; wr_in_pause = 1'b0;
    for (int c = 1; c <= 15 && done_cyc < 0; c++) begin
      tick(); rdy_in = !(c >= 2 && c <= 4); #1;
      if (!rdy_in && mem_wr) wr_in_pause = 1'b1;
      if (ls_done) begin done_cyc = c; void'(sb.pop_front()); ls_req = 1'b0; ls_we = 1'b0; end
    end
    rdy_in = 1'b1;
    total_cnt++;
    if (wr_in_pause) $display("FAIL pause_mem_wr got 1 expected 0"); else pass_cnt++;
    total_cnt++;
    if (done_cyc != 8) $display("FAIL pause_latency got %0d expected 8", done_cyc); else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_log.size() - wbase != 4) $display("FAIL pause_beat_count got %0d expected 4", wr_log.size() - wbase);
    else pass_cnt++;
    for (int k = 0; k < 4 && wbase + k < wr_log.size(); k++) begin
      total_cnt++;
      if (wr_log[wbase + k] !== exp_beats[k])
        $display("FAIL pause_beat[%0d] got %h:%h expected %h:%h", k, wr_log[wbase + k].addr,
                 wr_log[wbase + k].data, exp_beats[k].addr, exp_beats[k].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    int   done_cyc;
    bit   early_done;
    exp_t e;
    ram[12'h080] = 8'h11; ram[12'h081] = 8'h22; ram[12'h082] = 8'h33; ram[12'h083] = 8'h44;
    ram[12'h084] = 8'hA1; ram[12'h085] = 8'hB2; ram[12'h086] = 8'hC3; ram[12'h087] = 8'hD4;
    sb.push_back('{1'b0, 32'hD4C3B2A1});
    tick(); if_req = 1'b1; if_addr = 32'h80; #1;
    done_cyc = -1; early_done = 1'b0;
    for (int c = 1; c <= 15 && done_cyc < 0; c++) begin
      tick();
      if_flush = (c == 2);
      if (c == 3) if_addr = 32'h84;
      #1;
      if (c == 3) begin
        total_cnt++;
        if (mem_addr !== 32'h0) $display("FAIL flush_idle_addr got %h expected 00000000", mem_addr);
        else pass_cnt++;
      end
      if (if_done && c < 8) early_done = 1'b1;
      if (if_done) begin
        done_cyc = c; e = sb.pop_front(); if_req = 1'b0;
        total_cnt++;
        if (if_data !== e.data) $display("FAIL flush_refetch_data got %h expected %h", if_data, e.data);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (early_done || done_cyc != 8)
      $display("FAIL flush_timing got early=%0b done=%0d expected 0 8", early_done, done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   done_cyc;
    bit   done_seen;
    exp_t e;
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h500; ls_size = 2'b10; ls_wdata = 32'h11223344; #1;
    done_seen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin rst_in = 1'b1; ls_req = 1'b0; ls_we = 1'b0; end
      #1;
      if (ls_done) done_seen = 1'b1;
    end
    tick(); rst_in = 1'b0; #1;
    total_cnt++;
    if (done_seen || {if_done, ls_done, mem_wr, mem_addr, mem_dout, if_data, ls_rdata} !== '0)
      $display("FAIL midreset_outputs got addr=%h wr=%b dout=%h ifd=%h lsd=%h done=%b expected all 0",
               mem_addr, mem_wr, mem_dout, if_data, ls_rdata, done_seen);
    else pass_cnt++;
    sb.push_back('{1'b1, 32'hD4C3B2A1});
    tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h84; ls_size = 2'b10; #1;
    done_cyc = -1;
    for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
      tick(); #1;
      if (ls_done) begin
        done_cyc = c; e = sb.pop_front(); ls_req = 1'b0;
        total_cnt++;
        if (ls_rdata !== e.data) $display("FAIL post_reset_data got %h expected %h", ls_rdata, e.data);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_cyc != 5) $display("FAIL post_reset_latency got %0d expected 5", done_cyc); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    test_reset();
    test_fetch();
    test_store_arb();
    test_load();
    test_store_pause();
    test_flush();
    test_reset_mid();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard_left got %0d expected 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
